ov5640_cfg_seq: RTL and testbench
=================================

// Module: ov5640_cfg_seq
// PURPOSE
//  Register-init sequencer for the OV5640 SCCB write engine. After reset it waits a
//  power-up delay, then walks a configuration table of {addr[15:0],data[7:0]} entries
//  and issues one SCCB write per entry via the sccb_exec/sccb_done handshake. It sits
//  between the config ROM and the SCCB writer, and runs on that writer's sccb_clk.
// PARAMETERS
//  REG_NUM     8'd250     number of table entries (indices 0..REG_NUM-1)
//  PWR_DLY     16'd20000  clk cycles to wait after reset before the first write
//  SRST_DLY    16'd5000   clk cycles to wait after writing 0x3008 with data[7]=1 (soft reset)
//  TIMEOUT     16'd1000   max clk cycles from exec to sccb_done before an entry is abandoned
// PORTS
//  clk           in   1   sccb_clk from the SCCB writer; the only clock
//  rst           in   1   synchronous, active-high reset
//  cfg_start     in   1   1-cycle pulse: re-run the whole table (honoured in S_DONE only)
//  cfg_idx       out  8   table read index to the config ROM
//  cfg_rdata     in   24  ROM data {addr[15:0],data[7:0]}, valid 1 cycle after cfg_idx changes
//  sccb_exec     out  1   1-cycle write request to the SCCB writer
//  bit_ctrl      out  1   tied 1 (16-bit register address)
//  sccb_addr     out  16  register address for the current write
//  sccb_data_wr  out  8   register data for the current write
//  sccb_done     in   1   write-complete level from the writer (high >=1 cycle per write)
//  cfg_busy      out  1   high from reset release until S_DONE
//  cfg_done      out  1   high while in S_DONE (level)
//  cfg_err       out  1   sticky: >=1 entry timed out since last run start
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=S_PWR; cfg_idx=0; sccb_exec=0; sccb_addr=0; sccb_data_wr=0; bit_ctrl=1;
//   cfg_busy=1; cfg_done=0; cfg_err=0; delay counter=0; done_d=0.
//  done_rise = sccb_done & ~done_d, where done_d is sccb_done registered once.
//  FSM:
//   S_PWR   count to PWR_DLY-1, then -> S_FETCH.
//   S_FETCH cfg_idx is stable; wait 1 cycle for ROM latency -> S_LOAD.
//   S_LOAD  latch sccb_addr/sccb_data_wr from cfg_rdata; sccb_exec=1 for exactly this
//           cycle; clear timer -> S_WAIT.
//   S_WAIT  on done_rise -> S_POST. Otherwise, if timer==TIMEOUT-1, set cfg_err=1 -> S_POST.
//           Timer is 16 bit and does not wrap.
//   S_POST  wait until sccb_done==0 (writer back in idle). If the latched entry is
//           addr==16'h3008 and data[7]==1 -> S_SRST, else -> S_NEXT.
//   S_SRST  count to SRST_DLY-1 -> S_NEXT.
//   S_NEXT  if cfg_idx==REG_NUM-1 -> S_DONE (cfg_idx holds), else cfg_idx+1 -> S_FETCH.
//   S_DONE  cfg_done=1, cfg_busy=0. On cfg_start: cfg_idx=0, cfg_err=0 -> S_FETCH
//           (the power-up delay is not repeated).
//  Boundaries:
//   - sccb_exec is never asserted outside S_LOAD, so there is exactly one exec per entry,
//     including for timed-out entries.
//   - cfg_start outside S_DONE is ignored.
//   - sccb_done high on entry to S_WAIT (a stale level) produces no done_rise, because it
//     is already high in done_d.
//   - A done_rise arriving on the same cycle as the timeout counts as success:
//     cfg_err is not set.
//   - REG_NUM==1: one write, then S_DONE.
//   - rst in any state aborts immediately to reset values; the writer is not
//     notified (it completes or is reset by its own reset).
//   - sccb_addr/sccb_data_wr hold their value from S_LOAD until the next S_LOAD.
// TESTING
//  1 PWR_DLY=10, REG_NUM=3, writer model acks 40 cycles after exec
//    -> first exec exactly 12 cycles after rst release, 3 execs total, cfg_done=1, cfg_err=0.
//  2 ROM entry 1 = 24'h300882 -> the gap between done_rise #2 and exec #3 is
//    >= SRST_DLY+3 cycles; entry 24'h300802 -> no extra gap.
//  3 Model never acks entry 0 (TIMEOUT=50) -> exec #2 follows after ~52 cycles,
//    cfg_err=1 sticky, run completes.
//  4 In S_DONE, pulse cfg_start -> cfg_err clears, cfg_idx=0, execs resume with no
//    PWR_DLY wait; a cfg_start pulsed mid-run causes no change.
//  5 Assert rst while in S_WAIT of entry 2 -> next cycle all outputs are at reset values;
//    after release the sequence restarts at cfg_idx=0 with a full PWR_DLY.
//  6 sccb_done held high 5 cycles per ack -> exactly one advance per entry;
//    sccb_exec width is always 1 cycle.

Source files
------------

// File: rtl/ov5640_cfg_seq_if.sv
// Bus between the init sequencer, the config ROM and the SCCB writer.
// master: sequencer side; slave: ROM + writer side.
interface ov5640_cfg_seq_if;
  logic [7:0]  cfg_idx;
  logic [23:0] cfg_rdata;
  logic        sccb_exec;
  logic        bit_ctrl;
  logic [15:0] sccb_addr;
  logic [7:0]  sccb_data_wr;
  logic        sccb_done;

  modport master (
    output cfg_idx,
    output sccb_exec,
    output bit_ctrl,
    output sccb_addr,
    output sccb_data_wr,
    input  cfg_rdata,
    input  sccb_done
  );

  modport slave (
    input  cfg_idx,
    input  sccb_exec,
    input  bit_ctrl,
    input  sccb_addr,
    input  sccb_data_wr,
    output cfg_rdata,
    output sccb_done
  );
endinterface

// File: rtl/ov5640_cfg_seq.sv
// OV5640 register-init sequencer: power-up delay, then one SCCB
// write per ROM entry. Ports: clk, rst, cfg_start, bus, busy/done/err.
module ov5640_cfg_seq #(
  parameter logic [7:0]  REG_NUM  = 8'd250,
  parameter logic [15:0] PWR_DLY  = 16'd20000,
  parameter logic [15:0] SRST_DLY = 16'd5000,
  parameter logic [15:0] TIMEOUT  = 16'd1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  ov5640_cfg_seq_if.master        bus,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic                    cfg_err
);

  typedef enum logic [2:0] {
    S_PWR,
    S_FETCH,
    S_LOAD,
    S_WAIT,
    S_POST,
    S_SRST,
    S_NEXT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic        exec_q, exec_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        err_q, err_d;
  logic        sdone_q;
  logic        done_rise;
  logic        srst_hit;

  assign done_rise = bus.sccb_done & ~sdone_q;
  // Writing 0x3008 with bit 7 set soft-resets the sensor.
  assign srst_hit  = (addr_q == 16'h3008) & data_q[7];

  always_comb begin
    state_d = state_q;
    // Shared delay/timeout counter saturates instead of wrapping.
    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    idx_d   = idx_q;
    exec_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      S_PWR: begin
        if (cnt_q == PWR_DLY - 16'd1) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        addr_d  = bus.cfg_rdata[23:8];
        data_d  = bus.cfg_rdata[7:0];
        exec_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A rise on the timeout cycle still counts as success.
        if (done_rise) begin
          state_d = S_POST;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          err_d   = 1'b1;
          state_d = S_POST;
        end
      end
      S_POST: begin
        if (!bus.sccb_done) begin
          cnt_d   = '0;
          state_d = srst_hit ? S_SRST : S_NEXT;
        end
      end
      S_SRST: begin
        if (cnt_q == SRST_DLY - 16'd1) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == REG_NUM - 8'd1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (cfg_start) begin
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_PWR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PWR;
      cnt_q   <= '0;
      idx_q   <= '0;
      exec_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      sdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      exec_q  <= exec_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      sdone_q <= bus.sccb_done;
    end
  end

  assign bus.cfg_idx      = idx_q;
  assign bus.sccb_exec    = exec_q;
  assign bus.bit_ctrl     = 1'b1;
  assign bus.sccb_addr    = addr_q;
  assign bus.sccb_data_wr = data_q;
  assign cfg_busy         = (state_q != S_DONE);
  assign cfg_done         = (state_q == S_DONE);
  assign cfg_err          = err_q;

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Bench for ov5640_cfg_seq: ROM + SCCB writer models,
// write scoreboard, directed sequence of runs.
module tb_ov5640_cfg_seq;
  localparam logic [15:0] PWR  = 16'd10;
  localparam logic [7:0]  REGN = 8'd3;
  localparam logic [15:0] SRST = 16'd30;
  localparam logic [15:0] TMO  = 16'd50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_start = 1'b0;
  logic cfg_busy, cfg_done, cfg_err;

  ov5640_cfg_seq_if bus ();

  ov5640_cfg_seq #(
    .REG_NUM (REGN),
    .PWR_DLY (PWR),
    .SRST_DLY(SRST),
    .TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .bus      (bus),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_exec = 0;
  int ack_dly = 40;
  int hold = 1;
  int noack = -1;
  int wcnt = 0;
  int hcnt = 0;
  logic prev_exec = 1'b0;
  logic prev_done = 1'b0;
  logic [23:0] rom [0:2];
  logic [23:0] sb [$];
  int exec_cyc [$];
  int rise_cyc [$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // ROM: data follows cfg_idx one clock later.
  always @(negedge clk) begin
    bus.cfg_rdata = rom[bus.cfg_idx];
  end

  // SCCB writer: ack ack_dly cycles after exec, hold done.
  initial bus.sccb_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      wcnt = 0;
      hcnt = 0;
      bus.sccb_done = 1'b0;
    end else begin
      if (hcnt > 0) begin
        hcnt--;
        if (hcnt == 0) bus.sccb_done = 1'b0;
      end
      if (bus.sccb_exec) begin
        if (int'(bus.cfg_idx) != noack) wcnt = ack_dly;
      end else if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin
          bus.sccb_done = 1'b1;
          hcnt = hold;
        end
      end
    end
  end

  // Monitor: scoreboard on each exec, exec width, timestamps.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst) begin
      if (bus.sccb_exec) begin
        chk("exec_width", {31'b0, prev_exec}, 32'd0);
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow: observed %0h expected exec",
                 {bus.sccb_addr, bus.sccb_data_wr});
        end
        if (sb.size() > 0) begin
          chk("sb_write",
              {8'h0, bus.sccb_addr, bus.sccb_data_wr},
              {8'h0, sb.pop_front()});
        end
        exec_cyc.push_back(cyc);
        n_exec++;
      end
      if (bus.sccb_done && !prev_done) rise_cyc.push_back(cyc);
    end
    prev_exec = bus.sccb_exec;
    prev_done = bus.sccb_done;
  end

  task automatic push_run();
    for (int i = 0; i < 3; i++) sb.push_back(rom[i]);
    exec_cyc.delete();
    rise_cyc.delete();
    n_exec = 0;
  endtask

  task automatic chk_reset(string p);
    chk({p, "_exec"}, {31'b0, bus.sccb_exec}, 32'd0);
    chk({p, "_idx"}, {24'b0, bus.cfg_idx}, 32'd0);
    chk({p, "_addr"}, {16'b0, bus.sccb_addr}, 32'd0);
    chk({p, "_data"}, {24'b0, bus.sccb_data_wr}, 32'd0);
    chk({p, "_bitctl"}, {31'b0, bus.bit_ctrl}, 32'd1);
    chk({p, "_busy"}, {31'b0, cfg_busy}, 32'd1);
    chk({p, "_done"}, {31'b0, cfg_done}, 32'd0);
    chk({p, "_err"}, {31'b0, cfg_err}, 32'd0);
  endtask

  // Cycles from here until the first exec is seen.
  task automatic time_to_exec(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.sccb_exec) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_done(string tag);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (cfg_done) break;
    end
    chk({tag, "_done"}, {31'b0, cfg_done}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  int n;

  initial begin
    rom[0] = 24'h310311;
    rom[1] = 24'h300802;
    rom[2] = 24'h380099;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");

    // Run 1: power-up delay then three acked writes.
    push_run();
    @(negedge clk);
    rst = 1'b0;
    time_to_exec(n);
    chk("first_exec_lat", n, 32'd12);
    wait_done("run1");
    chk("run1_execs", n_exec, 32'd3);
    chk("run1_err", {31'b0, cfg_err}, 32'd0);
    chk("run1_busy", {31'b0, cfg_busy}, 32'd0);
    chk("run1_idx", {24'b0, bus.cfg_idx}, 32'd2);
    chk("nosrst_gap", {31'b0, (exec_cyc[2] - rise_cyc[1]) <= 5},
        32'd1);

    // Run 2: soft-reset entry adds the SRST delay.
    rom[1] = 24'h300882;
    push_run();
    pulse_start();
    chk("restart_idx", {24'b0, bus.cfg_idx}, 32'd0);
    time_to_exec(n);
    chk("restart_no_pwr", {31'b0, n <= 3 && n > 0}, 32'd1);
    wait_done("run2");
    chk("run2_execs", n_exec, 32'd3);
    chk("srst_gap",
        {31'b0, (exec_cyc[2] - rise_cyc[1]) >= int'(SRST) + 3},
        32'd1);

    // Run 3: entry 0 never acked -> timeout, sticky error.
    rom[1] = 24'h300802;
    noack = 0;
    push_run();
    pulse_start();
    wait_done("run3");
    chk("tmo_execs", n_exec, 32'd3);
    chk("tmo_err", {31'b0, cfg_err}, 32'd1);
    chk("tmo_gap",
        {31'b0, (exec_cyc[1] - exec_cyc[0]) >= int'(TMO) &&
                (exec_cyc[1] - exec_cyc[0]) <= int'(TMO) + 6},
        32'd1);

    // Run 4: restart clears error; mid-run start ignored.
    noack = -1;
    push_run();
    pulse_start();
    chk("err_clear", {31'b0, cfg_err}, 32'd0);
    chk("restart2_idx", {24'b0, bus.cfg_idx}, 32'd0);
    time_to_exec(n);
    repeat (5) @(posedge clk);
    pulse_start();
    chk("midrun_busy", {31'b0, cfg_busy}, 32'd1);
    wait_done("run4");
    chk("run4_execs", n_exec, 32'd3);
    chk("run4_err", {31'b0, cfg_err}, 32'd0);

    // Run 5: ack lands exactly on the timeout cycle.
    ack_dly = 49;
    push_run();
    pulse_start();
    wait_done("run5");
    chk("tie_execs", n_exec, 32'd3);
    chk("tie_err", {31'b0, cfg_err}, 32'd0);

    // Run 6: ack one cycle past the timeout.
    ack_dly = 50;
    push_run();
    pulse_start();
    wait_done("run6");
    chk("late_execs", n_exec, 32'd3);
    chk("late_err", {31'b0, cfg_err}, 32'd1);

    // Run 7: done held 5 cycles per ack.
    ack_dly = 3;
    hold = 5;
    push_run();
    pulse_start();
    wait_done("run7");
    chk("hold_execs", n_exec, 32'd3);
    chk("hold_err", {31'b0, cfg_err}, 32'd0);

    // Run 8: reset while waiting on entry 2.
    ack_dly = 40;
    hold = 1;
    push_run();
    pulse_start();
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (bus.sccb_exec && bus.cfg_idx == 8'd2) begin
        n = 1;
        break;
      end
    end
    chk("reach_idx2", n, 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("abort");
    push_run();
    @(negedge clk);
    rst = 1'b0;
    time_to_exec(n);
    chk("rerun_lat", n, 32'd12);
    chk("rerun_idx", {24'b0, bus.cfg_idx}, 32'd0);
    wait_done("run8");
    chk("run8_execs", n_exec, 32'd3);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
